alu_issue_arbiter: RTL and testbench
====================================

Name: alu_issue_arbiter

Overview:
- Shares one ALU between NREQ reservation-station banks (integer, branch, ...), each of which offers at most one operand-ready entry per cycle.
- Selects one requester per cycle using a round-robin pointer and returns a same-cycle combinational grant, so the winning bank frees its entry on that edge.
- Latches the winner into a one-entry issue register that drives the ALU input, with backpressure from the ALU full signal.
- Sits between the reservation-station pop logic and the ALU; flushed by the global clear.

Parameters:
- NREQ, 4, number of requesting banks (2..8).
- PTR_W, 3, width of the round-robin pointer; must satisfy 2^PTR_W >= NREQ.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- rdy_in  input  1  global pause; when low, state holds and no grants are issued.
- _clear  input  1  synchronous flush (mispredict).
- _req_valid  input  NREQ  bank i has a ready entry.
- _req_rob_id  input  5*NREQ  packed; bank i occupies bits [5i+4:5i].
- _req_type  input  7*NREQ  packed opcode.
- _req_op  input  4*NREQ  packed funct code.
- _req_v1  input  32*NREQ  packed operand 1.
- _req_v2  input  32*NREQ  packed operand 2 (immediate already substituted).
- _req_grant  output  NREQ  one-hot, combinational; bank pops on the same edge.
- _alu_full  input  1  ALU cannot accept this cycle.
- _alu_ready  output  1  issue register valid and ALU not full.
- _alu_rob_id  output  5  issue register field.
- _alu_type  output  7  issue register field.
- _alu_op  output  4  issue register field.
- _alu_v1  output  32  issue register field.
- _alu_v2  output  32  issue register field.

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - issue register valid=0, all fields 0, pointer=0.
  - _alu_ready=0 and _req_grant=0 while reset is asserted.
- State:
  - out_valid plus a field register.
  - ptr in 0..NREQ-1.
- Acceptance:
  - accept = out_valid && !_alu_full && rdy_in.
  - _alu_ready = out_valid && !_alu_full.
- Slot availability:
  - slot_free = !out_valid || accept.
- Grant:
  - Issued only if rdy_in && !_clear && slot_free && |_req_valid.
  - Winner = first valid requester scanning ptr, ptr+1, ... modulo NREQ.
  - _req_grant is one-hot at the winner, else all zero.
- Clock edge with a grant:
  - Fields load from the winner; out_valid <= 1.
  - ptr <= (winner+1) mod NREQ, wrapping at NREQ-1 to 0 (not at 2^PTR_W).
- Clock edge with accept and no grant: out_valid <= 0.
- No accept and no grant: hold everything.
- Latency:
  - A request seen at edge k is presented to the ALU during cycle k+1.
  - Sustained throughput is 1 per cycle while !_alu_full.
- Full backpressure:
  - If out_valid && _alu_full, no grants are issued; requesters keep valid asserted.
- _clear:
  - Takes priority over everything: out_valid <= 0, ptr <= 0, no grant that cycle.
  - _alu_ready is unaffected combinationally during the clear cycle.
- rdy_in low: no grants; out_valid, fields and ptr hold.
- Requesters outside 0..NREQ-1 do not exist; the pointer never addresses them.
- Reset mid-operation: a pending issue register entry is discarded immediately.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN.
- When defined, adds:
  - Output _perf_issue_cnt, 32 bits: counts accept cycles.
  - Output _perf_stall_cnt, 32 bits: counts cycles with |_req_valid && !slot_free && rdy_in.
  - Both counters reset to 0 on rst_n_in, are unaffected by _clear, and wrap modulo 2^32.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - ROB_ID_W=5, TYPE_W=7, OP_W=4, XLEN=32.
  - Opcode constants OP_RTYPE=7'b0110011 and OP_BRANCH=7'b1100011.
- Sub-module rr_picker (combinational): inputs req vector and ptr; outputs one-hot grant, winner index and any.

Test Plan:
- Reset: hold rst_n_in low with all _req_valid=1 -> _req_grant=0, _alu_ready=0. After release, the first grant goes to bank 0 and ptr becomes 1.
- Round-robin: NREQ=4, _req_valid=4'b1111 held, _alu_full=0 for 4 cycles -> grants 0001,0010,0100,1000. The ALU sees the rob_ids of banks 0,1,2,3 on consecutive cycles.
- Backpressure: issue bank 2 (rob_id 7), then assert _alu_full for 3 cycles -> _alu_ready=0 and no grants. On release, rob_id 7 is issued once and the next grant goes to bank 3.
- Wrap/skip: ptr=3, _req_valid=4'b0101 -> grant to bank 0 and ptr becomes 1. Next cycle the grant goes to bank 2.
- Clear: out_valid=1 with rob_id 12 and _clear=1 with requests pending -> no grant. Next cycle _alu_ready=0 and ptr=0.
- Pause: rdy_in=0 for 2 cycles with a pending entry -> fields stable, no grants, ptr unchanged. With ALU_ISSUE_PERF_EN, _perf_issue_cnt is unchanged.

Source files
------------

// File: rtl/alu_issue_arbiter_pkg.sv
// Shared widths, opcode constants and the issue-register record for the ALU
// issue arbiter.
package alu_issue_arbiter_pkg;

  localparam int ROB_ID_W = 5;
  localparam int TYPE_W   = 7;
  localparam int OP_W     = 4;
  localparam int XLEN     = 32;

  localparam logic [TYPE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [TYPE_W-1:0] OP_BRANCH = 7'b1100011;

  // One issued instruction as presented to the ALU
  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [TYPE_W-1:0]   opcode;
    logic [OP_W-1:0]     funct;
    logic [XLEN-1:0]     v1;
    logic [XLEN-1:0]     v2;
  } issue_t;

endpackage

// File: rtl/alu_issue_arbiter_rr_picker.sv
// Combinational round-robin picker: finds the first set request starting at
// ptr and wrapping at NREQ. The request vector is rotated by ptr through a
// doubled copy, so no index ever leaves 0..NREQ-1.
module rr_picker #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 3
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] winner,
  output logic             any
);

  logic [2*NREQ-1:0] req_rot2_s;
  logic [NREQ-1:0]   req_rot_s;
  logic [NREQ-1:0]   sel_rot_s;
  logic [2*NREQ-1:0] grant2_s;
  logic [PTR_W-1:0]  offset_s;
  logic [PTR_W:0]    sum_s;
  logic              found_s;

  assign req_rot2_s = {req, req} >> ptr;
  assign req_rot_s  = req_rot2_s[NREQ-1:0];
  assign any        = |req;

  // Lowest set bit of the rotated vector is the round-robin winner
  always_comb begin
    sel_rot_s = '0;
    offset_s  = '0;
    found_s   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_s && req_rot_s[k]) begin
        sel_rot_s[k] = 1'b1;
        offset_s     = PTR_W'(k);
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Rotate the one-hot back into bank order and form the winner index mod NREQ
  always_comb begin
    grant2_s = {{NREQ{1'b0}}, sel_rot_s} << ptr;
    grant    = grant2_s[NREQ-1:0] | grant2_s[2*NREQ-1:NREQ];
    sum_s    = {1'b0, ptr} + {1'b0, offset_s};
    if (sum_s >= (PTR_W+1)'(NREQ)) begin
      winner = PTR_W'(sum_s - (PTR_W+1)'(NREQ));
    end else begin
      winner = PTR_W'(sum_s);
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// ALU issue arbiter: round-robin selection among NREQ reservation-station
// banks into a one-entry issue register with ALU backpressure.
// Optional macro ALU_ISSUE_PERF_EN adds issue/stall performance counters.
module alu_issue_arbiter
  import alu_issue_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = 3
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     _clear,
  input  logic [NREQ-1:0]          _req_valid,
  input  logic [ROB_ID_W*NREQ-1:0] _req_rob_id,
  input  logic [TYPE_W*NREQ-1:0]   _req_type,
  input  logic [OP_W*NREQ-1:0]     _req_op,
  input  logic [XLEN*NREQ-1:0]     _req_v1,
  input  logic [XLEN*NREQ-1:0]     _req_v2,
  output logic [NREQ-1:0]          _req_grant,
  input  logic                     _alu_full,
  output logic                     _alu_ready,
  output logic [ROB_ID_W-1:0]      _alu_rob_id,
  output logic [TYPE_W-1:0]        _alu_type,
  output logic [OP_W-1:0]          _alu_op,
  output logic [XLEN-1:0]          _alu_v1,
  output logic [XLEN-1:0]          _alu_v2
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]              _perf_issue_cnt,
  output logic [31:0]              _perf_stall_cnt
`endif
);

  logic             valid_r;
  logic [PTR_W-1:0] ptr_r;
  issue_t           issue_r;

  logic [NREQ-1:0]  pick_grant_s;
  logic [PTR_W-1:0] winner_s;
  logic             any_s;
  logic             accept_s;
  logic             slot_free_s;
  logic             grant_en_s;
  logic [PTR_W-1:0] ptr_next_s;
  issue_t           pick_s;

  rr_picker #(.NREQ(NREQ), .PTR_W(PTR_W)) u_picker (
    .req    (_req_valid),
    .ptr    (ptr_r),
    .grant  (pick_grant_s),
    .winner (winner_s),
    .any    (any_s)
  );

  assign accept_s    = valid_r && !_alu_full && rdy_in;
  assign slot_free_s = !valid_r || accept_s;
  // Grant is gated by rst_n_in so banks never pop while reset is held
  assign grant_en_s  = rst_n_in && rdy_in && !_clear && slot_free_s && any_s;
  assign _req_grant  = grant_en_s ? pick_grant_s : {NREQ{1'b0}};
  assign _alu_ready  = valid_r && !_alu_full;

  assign _alu_rob_id = issue_r.rob_id;
  assign _alu_type   = issue_r.opcode;
  assign _alu_op     = issue_r.funct;
  assign _alu_v1     = issue_r.v1;
  assign _alu_v2     = issue_r.v2;

  // Unpack the winning bank's fields from the packed request buses
  always_comb begin
    pick_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner_s == PTR_W'(i)) begin
        pick_s.rob_id = _req_rob_id[i*ROB_ID_W +: ROB_ID_W];
        pick_s.opcode = _req_type[i*TYPE_W +: TYPE_W];
        pick_s.funct  = _req_op[i*OP_W +: OP_W];
        pick_s.v1     = _req_v1[i*XLEN +: XLEN];
        pick_s.v2     = _req_v2[i*XLEN +: XLEN];
      end else begin
        pick_s = pick_s;
      end
    end
  end

  // Pointer advances past the winner and wraps at NREQ, not at 2^PTR_W
  always_comb begin
    if (winner_s == PTR_W'(NREQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = winner_s + PTR_W'(1);
    end
  end

  // Issue register and round-robin pointer; clear flushes ahead of any grant
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_r <= 1'b0;
      ptr_r   <= '0;
      issue_r <= '0;
    end else if (_clear) begin
      valid_r <= 1'b0;
      ptr_r   <= '0;
    end else if (grant_en_s) begin
      valid_r <= 1'b1;
      ptr_r   <= ptr_next_s;
      issue_r <= pick_s;
    end else if (accept_s) begin
      valid_r <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  // Free-running accept and stall counters, untouched by the flush
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      _perf_issue_cnt <= 32'd0;
      _perf_stall_cnt <= 32'd0;
    end else begin
      if (accept_s) begin
        _perf_issue_cnt <= _perf_issue_cnt + 32'd1;
      end
      if (any_s && !slot_free_s && rdy_in) begin
        _perf_stall_cnt <= _perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter (NREQ=4): table of per-cycle
// stimulus with hand-derived expected grant/ready, plus a scoreboard queue of
// issued fields popped when the ALU is expected to accept.
module tb_alu_issue_arbiter;
  import alu_issue_arbiter_pkg::*;

  localparam int NREQ  = 4;
  localparam int PTR_W = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     rdy;
  logic                     clr;
  logic [NREQ-1:0]          req_valid;
  logic [ROB_ID_W*NREQ-1:0] req_rob_id;
  logic [TYPE_W*NREQ-1:0]   req_type;
  logic [OP_W*NREQ-1:0]     req_op;
  logic [XLEN*NREQ-1:0]     req_v1;
  logic [XLEN*NREQ-1:0]     req_v2;
  logic [NREQ-1:0]          req_grant;
  logic                     alu_full;
  logic                     alu_ready;
  logic [ROB_ID_W-1:0]      alu_rob_id;
  logic [TYPE_W-1:0]        alu_type;
  logic [OP_W-1:0]          alu_op;
  logic [XLEN-1:0]          alu_v1;
  logic [XLEN-1:0]          alu_v2;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0]              perf_issue_cnt;
  logic [31:0]              perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  alu_issue_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .rdy_in      (rdy),
    ._clear      (clr),
    ._req_valid  (req_valid),
    ._req_rob_id (req_rob_id),
    ._req_type   (req_type),
    ._req_op     (req_op),
    ._req_v1     (req_v1),
    ._req_v2     (req_v2),
    ._req_grant  (req_grant),
    ._alu_full   (alu_full),
    ._alu_ready  (alu_ready),
    ._alu_rob_id (alu_rob_id),
    ._alu_type   (alu_type),
    ._alu_op     (alu_op),
    ._alu_v1     (alu_v1),
    ._alu_v2     (alu_v2)
`ifdef ALU_ISSUE_PERF_EN
    ,
    ._perf_issue_cnt (perf_issue_cnt),
    ._perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct packed {
    logic [4:0]  rob;
    logic [6:0]  opc;
    logic [3:0]  fn;
    logic [31:0] v1;
    logic [31:0] v2;
  } exp_t;

  typedef struct {
    logic [3:0] valid;
    logic       full;
    logic       rdy;
    logic       clr;
    logic [4:0] base;
    logic [3:0] exp_grant;
    logic       exp_ready;
  } vec_t;

  vec_t vecs[25];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Fields bank b offers when the cycle's rob_id base is 'base'
  function automatic exp_t bank_fields(input int b, input logic [4:0] base);
    exp_t e;
    e.rob = base + 5'(b);
    e.opc = (b % 2 == 1) ? OP_BRANCH : OP_RTYPE;
    e.fn  = 4'(b + 3);
    e.v1  = 32'hC0DE_0000 + {27'd0, base} * 32'd16 + 32'(b);
    e.v2  = e.v1 ^ 32'h5A5A_F0F0;
    return e;
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic f, input logic r,
                       input logic c, input logic [4:0] base);
    exp_t e;
    req_valid = v;
    alu_full  = f;
    rdy       = r;
    clr       = c;
    for (int b = 0; b < NREQ; b++) begin
      e = bank_fields(b, base);
      req_rob_id[b*5 +: 5]  = e.rob;
      req_type[b*7 +: 7]    = e.opc;
      req_op[b*4 +: 4]      = e.fn;
      req_v1[b*32 +: 32]    = e.v1;
      req_v2[b*32 +: 32]    = e.v2;
    end
  endtask

  // Drive one cycle just after a rising edge, check mid-cycle, advance to the next edge
  task automatic run_vec(input vec_t v, input string tag);
    exp_t cur;
    drive(v.valid, v.full, v.rdy, v.clr, v.base);
    #1;
    check({tag, "_grant"}, 80'(req_grant), 80'(v.exp_grant));
    check({tag, "_ready"}, 80'(alu_ready), 80'(v.exp_ready));
    if (v.exp_ready) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_nonempty"}, 80'(0), 80'(1));
      end else begin
        if (v.rdy) cur = sb.pop_front();
        else       cur = sb[0];
        check({tag, "_fields"}, {alu_rob_id, alu_type, alu_op, alu_v1, alu_v2}, cur);
      end
    end
    for (int b = 0; b < NREQ; b++) begin
      if (v.exp_grant[b]) sb.push_back(bank_fields(b, v.base));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // valid, full, rdy, clr, base, exp_grant, exp_ready
    vecs[0]  = '{4'b1111, 1'b0, 1'b1, 1'b0, 5'd0,  4'b0001, 1'b0};
    vecs[1]  = '{4'b1111, 1'b0, 1'b1, 1'b0, 5'd4,  4'b0010, 1'b1};
    vecs[2]  = '{4'b1111, 1'b0, 1'b1, 1'b0, 5'd8,  4'b0100, 1'b1};
    vecs[3]  = '{4'b1111, 1'b0, 1'b1, 1'b0, 5'd12, 4'b1000, 1'b1};
    vecs[4]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 5'd0,  4'b0000, 1'b1};
    vecs[5]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 5'd0,  4'b0000, 1'b0};
    vecs[6]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 5'd5,  4'b0100, 1'b0};
    vecs[7]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 5'd0,  4'b0000, 1'b0};
    vecs[8]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 5'd0,  4'b0000, 1'b0};
    vecs[9]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 5'd0,  4'b0000, 1'b0};
    vecs[10] = '{4'b1111, 1'b0, 1'b1, 1'b0, 5'd16, 4'b1000, 1'b1};
    vecs[11] = '{4'b0000, 1'b0, 1'b1, 1'b0, 5'd0,  4'b0000, 1'b1};
    vecs[12] = '{4'b0100, 1'b0, 1'b1, 1'b0, 5'd20, 4'b0100, 1'b0};
    vecs[13] = '{4'b0101, 1'b0, 1'b1, 1'b0, 5'd0,  4'b0001, 1'b1};
    vecs[14] = '{4'b0101, 1'b0, 1'b1, 1'b0, 5'd24, 4'b0100, 1'b1};
    vecs[15] = '{4'b0000, 1'b0, 1'b1, 1'b0, 5'd0,  4'b0000, 1'b1};
    vecs[16] = '{4'b0001, 1'b0, 1'b1, 1'b0, 5'd12, 4'b0001, 1'b0};
    vecs[17] = '{4'b1111, 1'b0, 1'b1, 1'b1, 5'd0,  4'b0000, 1'b1};
    vecs[18] = '{4'b0000, 1'b0, 1'b1, 1'b0, 5'd0,  4'b0000, 1'b0};
    vecs[19] = '{4'b1111, 1'b0, 1'b1, 1'b0, 5'd0,  4'b0001, 1'b0};
    vecs[20] = '{4'b1111, 1'b0, 1'b0, 1'b0, 5'd8,  4'b0000, 1'b1};
    vecs[21] = '{4'b1111, 1'b0, 1'b0, 1'b0, 5'd8,  4'b0000, 1'b1};
    vecs[22] = '{4'b1111, 1'b0, 1'b1, 1'b0, 5'd8,  4'b0010, 1'b1};
    vecs[23] = '{4'b0000, 1'b0, 1'b1, 1'b0, 5'd0,  4'b0000, 1'b1};
    vecs[24] = '{4'b0000, 1'b0, 1'b1, 1'b0, 5'd0,  4'b0000, 1'b0};

    // Reset held with every bank requesting: nothing granted, nothing ready
    rst_n = 1'b0;
    drive(4'b1111, 1'b0, 1'b1, 1'b0, 5'd0);
    #12;
    check("reset_grant", 80'(req_grant), 80'(0));
    check("reset_ready", 80'(alu_ready), 80'(0));
    check("reset_rob_id", 80'(alu_rob_id), 80'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

`ifdef ALU_ISSUE_PERF_EN
    check("perf_issue", 80'(perf_issue_cnt), 80'(12));
    check("perf_stall", 80'(perf_stall_cnt), 80'(3));
`endif

    // Pointer sits at 2: bank 2 wins, then reset lands mid-cycle with the entry pending
    run_vec('{4'b1111, 1'b0, 1'b1, 1'b0, 5'd0, 4'b0100, 1'b0}, "pre_rst");
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 80'(alu_ready), 80'(0));
    check("midrst_grant", 80'(req_grant), 80'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_vec('{4'b1111, 1'b0, 1'b1, 1'b0, 5'd0, 4'b0001, 1'b0}, "post_rst0");
    run_vec('{4'b1111, 1'b0, 1'b1, 1'b0, 5'd0, 4'b0010, 1'b1}, "post_rst1");
    run_vec('{4'b0000, 1'b0, 1'b1, 1'b0, 5'd0, 4'b0000, 1'b1}, "post_rst2");
    run_vec('{4'b0000, 1'b0, 1'b1, 1'b0, 5'd0, 4'b0000, 1'b0}, "post_rst3");
    check("sb_drained", 80'(sb.size()), 80'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
